// File: rtl/blood_anim_if.sv
// Bus bundle between the blood animation controller and its environment
// (game logic, VGA timing, sprite ROM bank, display mixer).
interface blood_anim_if;
  logic       hit_p1;
  logic       hit_p2;
  logic [9:0] pos_x_p1;
  logic [9:0] pos_y_p1;
  logic [9:0] pos_x_p2;
  logic [9:0] pos_y_p2;
  logic       frame_tick;
  logic       video_on;
  logic [9:0] x;
  logic [9:0] y;
  logic [11:0] rom_color;
  logic [5:0] rom_row;
  logic [5:0] rom_col;
  logic [4:0] frame_sel;
  logic       busy;
  logic       owner;
  logic       pixel_on;
  logic [11:0] color_out;

  modport master (
    output hit_p1, hit_p2, pos_x_p1, pos_y_p1, pos_x_p2, pos_y_p2,
    output frame_tick, video_on, x, y, rom_color,
    input  rom_row, rom_col, frame_sel, busy, owner, pixel_on, color_out
  );

  modport slave (
    input  hit_p1, hit_p2, pos_x_p1, pos_y_p1, pos_x_p2, pos_y_p2,
    input  frame_tick, video_on, x, y, rom_color,
    output rom_row, rom_col, frame_sel, busy, owner, pixel_on, color_out
  );
endinterface

// File: rtl/blood_anim_ctrl.sv
// Blood-splatter sequencer/arbiter: grants the single effect round-robin, steps frames
// on vblank ticks, addresses the sprite ROM. Define BLOOD_MIRROR_EN to mirror P2's splatter.
module blood_anim_ctrl #(
  parameter int NUM_FRAMES  = 24,
  parameter int FRAME_TICKS = 4
) (
  input logic        clk,
  input logic        reset,
  blood_anim_if.slave bus
);
  localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, PLAY = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          pend_p1_q, pend_p1_d, pend_p2_q, pend_p2_d;
  logic          owner_q, owner_d, last_q, last_d, busy_q;
  logic [9:0]    ox_q, ox_d, oy_q, oy_d;
  logic [4:0]    frame_q, frame_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          grant_s, gnt_p2_s, set_p1_s, set_p2_s, clr_p1_s, clr_p2_s, retrig_s;

  logic          in_box_s, in_box_q;
  logic [5:0]    dx_s, dy_s, row_s, col_s, row_q, col_q;
  logic          pixel_on_q;
  logic [11:0]   color_q;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    frame_d  = frame_q;
    tick_d   = tick_q;
    grant_s  = 1'b0;
    gnt_p2_s = 1'b0;
    set_p1_s = 1'b0;
    set_p2_s = 1'b0;
    clr_p1_s = 1'b0;
    clr_p2_s = 1'b0;
    retrig_s = 1'b0;
    case (state_q)
      IDLE: begin
        set_p1_s = bus.hit_p1;
        set_p2_s = bus.hit_p2;
        if (pend_p1_q || pend_p2_q) begin
          grant_s  = 1'b1;
          gnt_p2_s = (pend_p1_q && pend_p2_q) ? ~last_q : pend_p2_q;
        end else begin
          grant_s  = 1'b0;
        end
      end
      PLAY: begin
        // only the non-owner queues; an owner hit restarts its own animation
        set_p1_s = bus.hit_p1 & owner_q;
        set_p2_s = bus.hit_p2 & ~owner_q;
        retrig_s = owner_q ? bus.hit_p2 : bus.hit_p1;
        if (retrig_s) begin
          ox_d    = owner_q ? bus.pos_x_p2 : bus.pos_x_p1;
          oy_d    = owner_q ? bus.pos_y_p2 : bus.pos_y_p1;
          frame_d = 5'd0;
          tick_d  = '0;
        end else if (bus.frame_tick) begin
          if (tick_q < TW'(FRAME_TICKS - 1)) begin
            tick_d = tick_q + TW'(1);
          end else begin
            tick_d = '0;
            if (frame_q < 5'(NUM_FRAMES - 1)) begin
              frame_d = frame_q + 5'd1;
            end else if (owner_q ? pend_p1_q : pend_p2_q) begin
              grant_s  = 1'b1;
              gnt_p2_s = ~owner_q;
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          tick_d = tick_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant_s) begin
      state_d  = PLAY;
      owner_d  = gnt_p2_s;
      last_d   = gnt_p2_s;
      ox_d     = gnt_p2_s ? bus.pos_x_p2 : bus.pos_x_p1;
      oy_d     = gnt_p2_s ? bus.pos_y_p2 : bus.pos_y_p1;
      frame_d  = 5'd0;
      tick_d   = '0;
      clr_p1_s = ~gnt_p2_s;
      clr_p2_s = gnt_p2_s;
    end else begin
      clr_p1_s = 1'b0;
      clr_p2_s = 1'b0;
    end
    // a new request on the same edge as a clear survives
    pend_p1_d = set_p1_s | (pend_p1_q & ~clr_p1_s);
    pend_p2_d = set_p2_s | (pend_p2_q & ~clr_p2_s);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pend_p1_q <= 1'b0;
      pend_p2_q <= 1'b0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      busy_q    <= 1'b0;
      ox_q      <= 10'd0;
      oy_q      <= 10'd0;
      frame_q   <= 5'd0;
      tick_q    <= '0;
    end else begin
      state_q   <= state_d;
      pend_p1_q <= pend_p1_d;
      pend_p2_q <= pend_p2_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      busy_q    <= (state_d == PLAY);
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      frame_q   <= frame_d;
      tick_q    <= tick_d;
    end
  end

  // box compare is 11 bits wide so a sprite near x/y=1023 does not wrap
  always_comb begin
    dx_s     = bus.x[5:0] - ox_q[5:0];
    dy_s     = bus.y[5:0] - oy_q[5:0];
    in_box_s = busy_q & bus.video_on
             & (bus.x >= ox_q) & ({1'b0, bus.x} < ({1'b0, ox_q} + 11'd64))
             & (bus.y >= oy_q) & ({1'b0, bus.y} < ({1'b0, oy_q} + 11'd64));
    row_s    = in_box_s ? dy_s : 6'd0;
`ifdef BLOOD_MIRROR_EN
    col_s    = in_box_s ? (owner_q ? (6'd63 - dx_s) : dx_s) : 6'd0;
`else
    col_s    = in_box_s ? dx_s : 6'd0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q      <= 6'd0;
      col_q      <= 6'd0;
      in_box_q   <= 1'b0;
      pixel_on_q <= 1'b0;
      color_q    <= 12'd0;
    end else begin
      row_q      <= row_s;
      col_q      <= col_s;
      in_box_q   <= in_box_s;
      pixel_on_q <= in_box_q & (bus.rom_color != 12'h000);
      color_q    <= (in_box_q && (bus.rom_color != 12'h000)) ? bus.rom_color : 12'h000;
    end
  end

  assign bus.rom_row   = row_q;
  assign bus.rom_col   = col_q;
  assign bus.frame_sel = frame_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;
  assign bus.pixel_on  = pixel_on_q;
  assign bus.color_out = color_q;
endmodule

// File: tb/tb_blood_anim_ctrl.sv
// Directed bench for blood_anim_ctrl: pixel-path vector table plus hand-written
// arbitration, retrigger, boundary and reset sequences.
module tb_blood_anim_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  blood_anim_if bus();

  blood_anim_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        vo;
    logic [11:0] rc;
    logic [5:0]  row;
    logic [5:0]  col;
    logic        pon;
    logic [11:0] cout;
  } vec_t;

  vec_t vecs [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
    end
  endtask

  task automatic apply_vec(input int i);
    bus.x         = vecs[i].x;
    bus.y         = vecs[i].y;
    bus.video_on  = vecs[i].vo;
    bus.rom_color = 12'h000;
    step();
    chk($sformatf("v%0d_row", i), 32'(bus.rom_row), 32'(vecs[i].row));
    chk($sformatf("v%0d_col", i), 32'(bus.rom_col), 32'(vecs[i].col));
    bus.rom_color = vecs[i].rc;
    step();
    chk($sformatf("v%0d_pon", i), 32'(bus.pixel_on), 32'(vecs[i].pon));
    chk($sformatf("v%0d_color", i), 32'(bus.color_out), 32'(vecs[i].cout));
    bus.video_on  = 1'b0;
    bus.rom_color = 12'h000;
  endtask

  task automatic chk_state(input string name, input logic b, input logic o, input logic [4:0] f);
    chk({name, "_busy"}, 32'(bus.busy), 32'(b));
    chk({name, "_owner"}, 32'(bus.owner), 32'(o));
    chk({name, "_frame"}, 32'(bus.frame_sel), 32'(f));
  endtask

  initial begin
    // origin (100,200)
    vecs[0]  = '{10'd100, 10'd200, 1'b1, 12'hABC, 6'd0,  6'd0,  1'b1, 12'hABC};
    vecs[1]  = '{10'd163, 10'd263, 1'b1, 12'h123, 6'd63, 6'd63, 1'b1, 12'h123};
    vecs[2]  = '{10'd164, 10'd200, 1'b1, 12'hFFF, 6'd0,  6'd0,  1'b0, 12'h000};
    vecs[3]  = '{10'd99,  10'd200, 1'b1, 12'hFFF, 6'd0,  6'd0,  1'b0, 12'h000};
    vecs[4]  = '{10'd120, 10'd264, 1'b1, 12'hFFF, 6'd0,  6'd0,  1'b0, 12'h000};
    vecs[5]  = '{10'd110, 10'd205, 1'b0, 12'hFFF, 6'd0,  6'd0,  1'b0, 12'h000};
    vecs[6]  = '{10'd110, 10'd205, 1'b1, 12'h000, 6'd5,  6'd10, 1'b0, 12'h000};
    vecs[7]  = '{10'd105, 10'd230, 1'b1, 12'hF00, 6'd30, 6'd5,  1'b1, 12'hF00};
    // origin (980,900), after retrigger
    vecs[8]  = '{10'd1023, 10'd900, 1'b1, 12'h0F0, 6'd0,  6'd43, 1'b1, 12'h0F0};
    vecs[9]  = '{10'd979,  10'd900, 1'b1, 12'h0F0, 6'd0,  6'd0,  1'b0, 12'h000};
    vecs[10] = '{10'd1000, 10'd964, 1'b1, 12'h0F0, 6'd0,  6'd0,  1'b0, 12'h000};
    vecs[11] = '{10'd980,  10'd963, 1'b1, 12'h00F, 6'd63, 6'd0,  1'b1, 12'h00F};

    reset = 1'b1;
    bus.hit_p1 = 1'b0; bus.hit_p2 = 1'b0;
    bus.pos_x_p1 = 10'd100; bus.pos_y_p1 = 10'd200;
    bus.pos_x_p2 = 10'd0;   bus.pos_y_p2 = 10'd0;
    bus.frame_tick = 1'b0; bus.video_on = 1'b0;
    bus.x = 10'd0; bus.y = 10'd0; bus.rom_color = 12'h000;
    step(); step();
    reset = 1'b0;
    chk_state("rst", 1'b0, 1'b0, 5'd0);
    chk("rst_row", 32'(bus.rom_row), 32'd0);
    chk("rst_col", 32'(bus.rom_col), 32'd0);
    chk("rst_pon", 32'(bus.pixel_on), 32'd0);
    chk("rst_color", 32'(bus.color_out), 32'd0);

    // single P1 hit: pending after one edge, busy after two
    bus.hit_p1 = 1'b1;
    step();
    bus.hit_p1 = 1'b0;
    chk("hit_pend_busy", 32'(bus.busy), 32'd0);
    step();
    chk_state("grant_p1", 1'b1, 1'b0, 5'd0);

    for (int i = 0; i < 8; i++) apply_vec(i);

    tick(3);
    chk("tick3_frame", 32'(bus.frame_sel), 32'd0);
    tick(1);
    chk("tick4_frame", 32'(bus.frame_sel), 32'd1);
    tick(36);
    chk("frame10", 32'(bus.frame_sel), 32'd10);

    // retrigger by owner: new origin, frame and tick counter back to 0
    bus.pos_x_p1 = 10'd980; bus.pos_y_p1 = 10'd900;
    bus.hit_p1 = 1'b1;
    step();
    bus.hit_p1 = 1'b0;
    chk_state("retrig", 1'b1, 1'b0, 5'd0);
    tick(3);
    chk("retrig_t3", 32'(bus.frame_sel), 32'd0);
    tick(1);
    chk("retrig_t4", 32'(bus.frame_sel), 32'd1);
    for (int i = 8; i < 12; i++) apply_vec(i);
    tick(91);
    chk_state("retrig_t95", 1'b1, 1'b0, 5'd23);
    tick(1);
    chk_state("retrig_done", 1'b0, 1'b0, 5'd23);
    step(); step();
    chk("idle_stays", 32'(bus.busy), 32'd0);

    // tie after reset goes to P1, then P2 served straight from PLAY
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_state("rst2", 1'b0, 1'b0, 5'd0);
    bus.pos_x_p1 = 10'd10;  bus.pos_y_p1 = 10'd20;
    bus.pos_x_p2 = 10'd500; bus.pos_y_p2 = 10'd600;
    bus.hit_p1 = 1'b1; bus.hit_p2 = 1'b1;
    step();
    bus.hit_p1 = 1'b0; bus.hit_p2 = 1'b0;
    step();
    chk_state("tie", 1'b1, 1'b0, 5'd0);
    tick(95);
    chk_state("tie_t95", 1'b1, 1'b0, 5'd23);
    tick(1);
    chk_state("handoff_p2", 1'b1, 1'b1, 5'd0);
    bus.x = 10'd505; bus.y = 10'd600; bus.video_on = 1'b1;
    step();
    chk("p2_row", 32'(bus.rom_row), 32'd0);
`ifdef BLOOD_MIRROR_EN
    chk("p2_col", 32'(bus.rom_col), 32'd58);
`else
    chk("p2_col", 32'(bus.rom_col), 32'd5);
`endif
    bus.video_on = 1'b0;
    tick(95);
    chk_state("p2_t95", 1'b1, 1'b1, 5'd23);
    tick(1);
    chk_state("p2_done", 1'b0, 1'b1, 5'd23);

    // reset mid-animation with the other player pending
    bus.pos_x_p2 = 10'd300; bus.pos_y_p2 = 10'd300;
    bus.hit_p2 = 1'b1;
    step();
    bus.hit_p2 = 1'b0;
    step();
    chk_state("p2_again", 1'b1, 1'b1, 5'd0);
    tick(60);
    chk("mid_frame15", 32'(bus.frame_sel), 32'd15);
    bus.hit_p1 = 1'b1;
    step();
    bus.hit_p1 = 1'b0;
    chk_state("p1_queued", 1'b1, 1'b1, 5'd15);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_state("mid_rst", 1'b0, 1'b0, 5'd0);
    chk("mid_rst_pon", 32'(bus.pixel_on), 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("no_stale_grant", 32'(bus.busy), 32'd0);
    bus.hit_p1 = 1'b1;
    step();
    bus.hit_p1 = 1'b0;
    step();
    chk_state("post_rst_grant", 1'b1, 1'b0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
